pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline: drives enable/flush of PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves load-use hazards, taken-branch/jump flushes, variable-latency data-memory waits with timeout, and halt/drain requests.
- Sits beside the pipeline registers; all controls are Mealy outputs of the registered FSM state plus current-cycle inputs.

Parameters:
- MEM_TIMEOUT, 16, max MEM_WAIT cycles before error; legal 2..255; 8-bit wait counter.
- DRAIN_DEPTH, 4, bubble cycles injected before halt is acknowledged; legal 1..15; 4-bit drain counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- IFID_Rs_in  in  5  source reg rs of instruction in ID.
- IFID_Rt_in  in  5  source reg rt of instruction in ID.
- IDEX_RtorRd_in  in  5  destination reg of instruction in EX.
- IDEX_MemRead_in  in  1  EX instruction is a load.
- branch_taken_in  in  1  EX resolved taken branch.
- jump_in  in  1  ID decoded jump.
- mem_req_in  in  1  MEM-stage instruction accesses data memory.
- mem_ready_in  in  1  data memory completes access this cycle.
- halt_req_in  in  1  level halt request.
- PC_en_o, IFID_en_o, IDEX_en_o, EXMEM_en_o, MEMWB_en_o  out  1 each  register load enables.
- IFID_flush_o, IDEX_flush_o, MEMWB_flush_o  out  1 each  load a bubble (all-zero controls) instead of data.
- halt_ack_o  out  1  pipeline drained and frozen.
- mem_err_o  out  1  sticky memory-timeout error.
- state_o  out  3  current FSM state code.

Behaviour:
- States: RUN=0, MEM_WAIT=1, DRAIN=2, HALTED=3, ERR=4. Reset (async, reset=0) -> RUN, wait_cnt=0, drain_cnt=0, mem_err_o=0. During reset all enables 0, all flushes 0, halt_ack_o=0.
- Default (RUN, no event): all enables 1, all flushes 0.
- RUN priority, highest first:
  1. Memory stall: mem_req_in=1 and mem_ready_in=0 -> same cycle all enables 0, MEMWB_en_o=1, MEMWB_flush_o=1 (WB instruction retires once, not repeated); next state MEM_WAIT, wait_cnt<=1.
  2. branch_taken_in -> IFID_flush_o=1, IDEX_flush_o=1, PC_en_o=1.
  3. Load-use: IDEX_MemRead_in=1, IDEX_RtorRd_in!=0, and it equals IFID_Rs_in or IFID_Rt_in -> PC_en_o=0, IFID_en_o=0, IDEX_flush_o=1; one cycle only, no state change.
  4. jump_in -> IFID_flush_o=1.
- halt_req_in=1 in RUN without memory stall: current cycle behaves per rules 2-4; next state DRAIN, drain_cnt<=DRAIN_DEPTH.
- MEM_WAIT: mem_ready_in=1 -> default RUN outputs this cycle, next RUN, wait_cnt<=0. Otherwise freeze outputs as in rule 1 with MEMWB_flush_o=1; wait_cnt increments; when wait_cnt=MEM_TIMEOUT-1 and still not ready -> next ERR.
- DRAIN: PC_en_o=0, IFID_flush_o=1, downstream enables 1; drain_cnt decrements per cycle. A memory stall during DRAIN freezes exactly as in MEM_WAIT (drain_cnt held) with the same timeout rule; returns to DRAIN. At drain_cnt=1 with no stall -> HALTED. If halt_req_in drops during DRAIN, finish the drain, then go to RUN instead of HALTED.
- HALTED: all enables 0, halt_ack_o=1; halt_req_in=0 -> next RUN (halt_ack_o falls with the state change).
- ERR: all enables 0, mem_err_o=1; exit only via reset.
- Branch/load-use/jump inputs are ignored outside RUN.

Optional Feature:
- Macro HAZ_PERF_EN. Defined: adds outputs stall_cnt_o[31:0] (increments each cycle PC_en_o=0 in RUN or MEM_WAIT) and flush_cnt_o[31:0] (increments each cycle IFID_flush_o or IDEX_flush_o is asserted in RUN); both wrap at 2^32 and clear on reset. Undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Load-use: IDEX_MemRead_in=1, IDEX_RtorRd_in=5, IFID_Rt_in=5 -> exactly 1 cycle of PC_en_o=0, IFID_en_o=0, IDEX_flush_o=1. Repeat with RtorRd=0 -> no stall.
- Branch plus load-use in the same cycle -> IFID_flush_o=1, IDEX_flush_o=1, PC_en_o=1; no stall.
- Memory wait: mem_req_in=1, mem_ready_in low for 3 cycles then high -> 3 frozen cycles with MEMWB_flush_o=1, state_o=1, RUN on cycle 4.
- Timeout: MEM_TIMEOUT=4, mem_ready_in held 0 -> state_o=4 after 4 stalled cycles; mem_err_o stays 1 until reset=0.
- Halt: pulse halt_req_in high and hold -> 4 DRAIN cycles with IFID_flush_o=1, then halt_ack_o=1; drop the request -> RUN next cycle.
- Async reset asserted mid-MEM_WAIT -> immediate state_o=0 and all enables 0, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall/flush sequencer for a 5-stage pipeline. It drives the load
// enables and bubble-flush controls of the PC, IF/ID, ID/EX, EX/MEM and
// MEM/WB registers. It resolves load-use hazards, taken-branch and jump
// flushes, variable-latency data-memory waits with a timeout, and
// halt/drain requests. The FSM state is registered. The pipeline controls
// are Mealy outputs of that state plus the current-cycle inputs.
//
// Parameters:
//   MEM_TIMEOUT  max consecutive memory-stall cycles before the error
//                state (legal 2..255, 8-bit wait counter)
//   DRAIN_DEPTH  bubble cycles injected before a halt is acknowledged
//                (legal 1..15, 4-bit drain counter)
//
// Ports:
//   clk              clock, rising edge
//   reset            asynchronous reset, active low
//   IFID_Rs_in       rs of the instruction in ID
//   IFID_Rt_in       rt of the instruction in ID
//   IDEX_RtorRd_in   destination register of the instruction in EX
//   IDEX_MemRead_in  instruction in EX is a load
//   branch_taken_in  EX resolved a taken branch
//   jump_in          ID decoded a jump
//   mem_req_in       MEM-stage instruction accesses data memory
//   mem_ready_in     data memory completes the access this cycle
//   halt_req_in      level-sensitive halt request
//   *_en_o           pipeline register load enables
//   *_flush_o        load a bubble instead of data
//   halt_ack_o       pipeline drained and frozen
//   mem_err_o        sticky memory-timeout error
//   state_o          current FSM state code
//
// Optional feature (macro HAZ_PERF_EN):
//   Adds the stall_cnt_o[31:0] and flush_cnt_o[31:0] performance counters.
//   Both counters wrap and both clear on reset.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned DRAIN_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  IFID_Rs_in,
    input  logic [4:0]  IFID_Rt_in,
    input  logic [4:0]  IDEX_RtorRd_in,
    input  logic        IDEX_MemRead_in,
    input  logic        branch_taken_in,
    input  logic        jump_in,
    input  logic        mem_req_in,
    input  logic        mem_ready_in,
    input  logic        halt_req_in,
    output logic        PC_en_o,
    output logic        IFID_en_o,
    output logic        IDEX_en_o,
    output logic        EXMEM_en_o,
    output logic        MEMWB_en_o,
    output logic        IFID_flush_o,
    output logic        IDEX_flush_o,
    output logic        MEMWB_flush_o,
    output logic        halt_ack_o,
    output logic        mem_err_o,
    output logic [2:0]  state_o
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    typedef enum logic [2:0] {
        StRun     = 3'd0,
        StMemWait = 3'd1,
        StDrain   = 3'd2,
        StHalted  = 3'd3,
        StErr     = 3'd4
    } state_t;

    localparam logic [7:0] WaitLast  = 8'(MEM_TIMEOUT - 1);
    localparam logic [3:0] DrainInit = 4'(DRAIN_DEPTH);

    state_t     r_state;
    logic [7:0] r_wait_cnt;
    logic [3:0] r_drain_cnt;
    logic       r_halt_drop;
    logic       r_mem_err;

    logic       w_mem_stall;
    logic       w_load_use;
    logic       w_wait_last;
    logic       w_halt_keep;

    assign w_mem_stall = mem_req_in && !mem_ready_in;
    // Register 0 is hard-wired to zero, so a load into r0 creates no hazard.
    assign w_load_use  = IDEX_MemRead_in && (IDEX_RtorRd_in != 5'd0) &&
                         ((IDEX_RtorRd_in == IFID_Rs_in) || (IDEX_RtorRd_in == IFID_Rt_in));
    assign w_wait_last = (r_wait_cnt == WaitLast);
    // Halt only if the request was never released during the whole drain.
    assign w_halt_keep = halt_req_in && !r_halt_drop;

    // ------------------------------------------------------------------
    // State sequencing
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= StRun;
            r_wait_cnt  <= 8'd0;
            r_drain_cnt <= 4'd0;
            r_halt_drop <= 1'b0;
            r_mem_err   <= 1'b0;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (w_mem_stall) begin
                        r_state    <= StMemWait;
                        r_wait_cnt <= 8'd1;
                    end else if (halt_req_in) begin
                        r_state     <= StDrain;
                        r_drain_cnt <= DrainInit;
                        r_halt_drop <= 1'b0;
                        r_wait_cnt  <= 8'd0;
                    end
                end
                StMemWait: begin
                    if (mem_ready_in) begin
                        r_state    <= StRun;
                        r_wait_cnt <= 8'd0;
                    end else if (w_wait_last) begin
                        r_state   <= StErr;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                StDrain: begin
                    if (!halt_req_in) begin
                        r_halt_drop <= 1'b1;
                    end
                    // A stall inside the drain holds drain_cnt and counts wait cycles.
                    if (w_mem_stall) begin
                        if (w_wait_last) begin
                            r_state   <= StErr;
                            r_mem_err <= 1'b1;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 8'd1;
                        end
                    end else begin
                        r_wait_cnt <= 8'd0;
                        if (r_drain_cnt <= 4'd1) begin
                            r_drain_cnt <= 4'd0;
                            r_state     <= w_halt_keep ? StHalted : StRun;
                        end else begin
                            r_drain_cnt <= r_drain_cnt - 4'd1;
                        end
                    end
                end
                StHalted: begin
                    if (!halt_req_in) begin
                        r_state <= StRun;
                    end
                end
                StErr: begin
                    r_state <= StErr;
                end
                default: begin
                    r_state <= StRun;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pipeline controls (Mealy). They are gated by reset so that the
    // pipeline freezes immediately when reset is asserted.
    // ------------------------------------------------------------------
    always_comb begin
        PC_en_o       = 1'b0;
        IFID_en_o     = 1'b0;
        IDEX_en_o     = 1'b0;
        EXMEM_en_o    = 1'b0;
        MEMWB_en_o    = 1'b0;
        IFID_flush_o  = 1'b0;
        IDEX_flush_o  = 1'b0;
        MEMWB_flush_o = 1'b0;
        halt_ack_o    = 1'b0;
        if (reset) begin
            unique case (r_state)
                StRun: begin
                    if (w_mem_stall) begin
                        // The WB instruction retires once. A bubble then
                        // refills MEM/WB so that it does not retire again.
                        MEMWB_en_o    = 1'b1;
                        MEMWB_flush_o = 1'b1;
                    end else begin
                        PC_en_o    = 1'b1;
                        IFID_en_o  = 1'b1;
                        IDEX_en_o  = 1'b1;
                        EXMEM_en_o = 1'b1;
                        MEMWB_en_o = 1'b1;
                        if (branch_taken_in) begin
                            IFID_flush_o = 1'b1;
                            IDEX_flush_o = 1'b1;
                        end else if (w_load_use) begin
                            PC_en_o      = 1'b0;
                            IFID_en_o    = 1'b0;
                            IDEX_flush_o = 1'b1;
                        end else if (jump_in) begin
                            IFID_flush_o = 1'b1;
                        end
                    end
                end
                StMemWait: begin
                    if (mem_ready_in) begin
                        PC_en_o    = 1'b1;
                        IFID_en_o  = 1'b1;
                        IDEX_en_o  = 1'b1;
                        EXMEM_en_o = 1'b1;
                        MEMWB_en_o = 1'b1;
                    end else begin
                        MEMWB_en_o    = 1'b1;
                        MEMWB_flush_o = 1'b1;
                    end
                end
                StDrain: begin
                    if (w_mem_stall) begin
                        MEMWB_en_o    = 1'b1;
                        MEMWB_flush_o = 1'b1;
                    end else begin
                        // Fetch is held. IF/ID loads bubbles while the
                        // instructions already downstream keep flowing out.
                        IFID_en_o    = 1'b1;
                        IDEX_en_o    = 1'b1;
                        EXMEM_en_o   = 1'b1;
                        MEMWB_en_o   = 1'b1;
                        IFID_flush_o = 1'b1;
                    end
                end
                StHalted: begin
                    halt_ack_o = 1'b1;
                end
                StErr: begin
                    halt_ack_o = 1'b0;
                end
                default: begin
                    halt_ack_o = 1'b0;
                end
            endcase
        end
    end

    assign mem_err_o = r_mem_err;
    assign state_o   = r_state;

`ifdef HAZ_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic        w_stall_evt;
    logic        w_flush_evt;

    assign w_stall_evt = !PC_en_o && ((r_state == StRun) || (r_state == StMemWait));
    assign w_flush_evt = (IFID_flush_o || IDEX_flush_o) && (r_state == StRun);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (w_stall_evt) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_flush_evt) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed self-checking bench for pipe_hazard_ctrl, built with
// MEM_TIMEOUT=4 and DRAIN_DEPTH=4. Inputs change on the falling edge. The
// Mealy outputs are sampled 1 ns later. Each expected value is a
// hand-computed 13-bit control vector with this layout:
//   {PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en,
//    IFID_flush, IDEX_flush, MEMWB_flush, halt_ack, mem_err, state[2:0]}
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam logic [12:0] V_RST   = 13'b00000_000_0_0_000;
    localparam logic [12:0] V_RUN   = 13'b11111_000_0_0_000;
    localparam logic [12:0] V_LU    = 13'b00111_010_0_0_000;
    localparam logic [12:0] V_BR    = 13'b11111_110_0_0_000;
    localparam logic [12:0] V_JMP   = 13'b11111_100_0_0_000;
    localparam logic [12:0] V_STALL = 13'b00001_001_0_0_000;
    localparam logic [12:0] V_FRZ   = 13'b00001_001_0_0_001;
    localparam logic [12:0] V_MWRDY = 13'b11111_000_0_0_001;
    localparam logic [12:0] V_DRAIN = 13'b01111_100_0_0_010;
    localparam logic [12:0] V_DFRZ  = 13'b00001_001_0_0_010;
    localparam logic [12:0] V_HALT  = 13'b00000_000_1_0_011;
    localparam logic [12:0] V_ERR   = 13'b00000_000_0_1_100;

    logic       clk;
    logic       reset;
    logic [4:0] rs, rt, rd;
    logic       memrd, br, jmp, req, rdy, halt;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_fl, idex_fl, memwb_fl, halt_ack, mem_err;
    logic [2:0] state;
    logic [12:0] ctl;

    int n_checks = 0;
    int n_errors = 0;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (4),
        .DRAIN_DEPTH (4)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .IFID_Rs_in      (rs),
        .IFID_Rt_in      (rt),
        .IDEX_RtorRd_in  (rd),
        .IDEX_MemRead_in (memrd),
        .branch_taken_in (br),
        .jump_in         (jmp),
        .mem_req_in      (req),
        .mem_ready_in    (rdy),
        .halt_req_in     (halt),
        .PC_en_o         (pc_en),
        .IFID_en_o       (ifid_en),
        .IDEX_en_o       (idex_en),
        .EXMEM_en_o      (exmem_en),
        .MEMWB_en_o      (memwb_en),
        .IFID_flush_o    (ifid_fl),
        .IDEX_flush_o    (idex_fl),
        .MEMWB_flush_o   (memwb_fl),
        .halt_ack_o      (halt_ack),
        .mem_err_o       (mem_err),
        .state_o         (state)
    );

    assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                  ifid_fl, idex_fl, memwb_fl, halt_ack, mem_err, state};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] i_rs, input logic [4:0] i_rt,
                          input logic [4:0] i_rd, input logic i_memrd,
                          input logic i_br, input logic i_jmp, input logic i_req,
                          input logic i_rdy, input logic i_halt);
        rs    = i_rs;
        rt    = i_rt;
        rd    = i_rd;
        memrd = i_memrd;
        br    = i_br;
        jmp   = i_jmp;
        req   = i_req;
        rdy   = i_rdy;
        halt  = i_halt;
    endtask

    // Called on a falling edge: sample 1 ns later, then move past the next rising edge.
    task automatic go(input string tag, input logic [12:0] exp);
        #1;
        check(tag, ctl, exp);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check("reset", ctl, V_RST);
        @(negedge clk);
        reset = 1'b1;

        // Hazard priority in RUN.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); go("idle", V_RUN);
        set_in(1, 5, 5, 1, 0, 0, 0, 0, 0); go("lu_rt", V_LU);
        set_in(1, 5, 5, 0, 0, 0, 0, 0, 0); go("lu_one_cycle", V_RUN);
        set_in(7, 2, 7, 1, 0, 0, 0, 0, 0); go("lu_rs", V_LU);
        set_in(0, 0, 0, 1, 0, 0, 0, 0, 0); go("lu_r0", V_RUN);
        set_in(3, 4, 9, 1, 0, 0, 0, 0, 0); go("lu_nomatch", V_RUN);
        set_in(1, 5, 5, 1, 1, 0, 0, 0, 0); go("br_over_lu", V_BR);
        set_in(1, 5, 5, 1, 0, 1, 0, 0, 0); go("lu_over_jmp", V_LU);
        set_in(0, 0, 0, 0, 0, 1, 0, 0, 0); go("jump", V_JMP);

        // Memory wait: 3 stalled cycles, then ready.
        set_in(0, 0, 0, 0, 1, 0, 1, 0, 0); go("mw_enter_br", V_STALL);
        set_in(1, 5, 5, 1, 1, 1, 1, 0, 0); go("mw_frz_ignore", V_FRZ);
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); go("mw_frz2", V_FRZ);
        set_in(0, 0, 0, 0, 0, 0, 1, 1, 0); go("mw_ready", V_MWRDY);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); go("mw_back", V_RUN);

        // Halt held: 4 drain cycles, then acknowledge, then release.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1); go("halt_req", V_RUN);
        for (int i = 0; i < 4; i++) go("drain", V_DRAIN);
        go("halted", V_HALT);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); go("halted_release", V_HALT);
        go("halt_exit", V_RUN);

        // Halt dropped mid-drain: drain completes, then RUN.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1); go("h2_req", V_RUN);
        go("h2_drain", V_DRAIN);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) go("h2_drain", V_DRAIN);
        go("h2_run", V_RUN);

        // Memory stall inside a drain holds the drain count.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1); go("h3_req", V_RUN);
        go("h3_d1", V_DRAIN);
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 1); go("h3_frz", V_DFRZ);
        set_in(0, 0, 0, 0, 0, 0, 1, 1, 1); go("h3_d2", V_DRAIN);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1); go("h3_d3", V_DRAIN);
        go("h3_d4", V_DRAIN);
        go("h3_halted", V_HALT);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); go("h3_release", V_HALT);
        go("h3_run", V_RUN);

        // Timeout with MEM_TIMEOUT=4: ERR after 4 stalled cycles, sticky.
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); go("to_enter", V_STALL);
        for (int i = 0; i < 3; i++) go("to_frz", V_FRZ);
        go("to_err", V_ERR);
        set_in(0, 0, 0, 0, 1, 0, 0, 1, 0); go("err_hold1", V_ERR);
        go("err_hold2", V_ERR);
        reset = 1'b0;
        go("err_reset", V_RST);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        go("post_reset", V_RUN);

        // Asynchronous reset in the middle of MEM_WAIT.
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); go("ar_enter", V_STALL);
        go("ar_frz", V_FRZ);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", ctl, V_RST);
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        go("ar_run", V_RUN);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
